// File: rtl/mem_access_ctrl.sv
// Single-request load/store initiator for a 512x32 synchronous RAM; all outputs registered.
// Optional MEM_BOUNDS_CHECK_EN rejects addresses with MARin[31:ADDR_WIDTH] != 0 (Done+Error, no strobe).
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int READ_WAIT  = 1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  Start,
    input  logic                  WriteReq,
    input  logic [31:0]           MARin,
    input  logic [DATA_WIDTH-1:0] MDRin,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [DATA_WIDTH-1:0] MDRdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemDataOut,
    input  logic [DATA_WIDTH-1:0] Mdatain
);

    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        FINISH,
        BND_ERR
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] dout_nxt;
    logic [DATA_WIDTH-1:0] mdr_nxt;
    logic                  err_nxt;

`ifndef MEM_BOUNDS_CHECK_EN
    // Upper address bits are intentionally discarded: addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^MARin[31:ADDR_WIDTH];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = MemAddress;
        dout_nxt  = MemDataOut;
        mdr_nxt   = MDRdata;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    addr_nxt = MARin[ADDR_WIDTH-1:0];
                    dout_nxt = MDRin;
`ifdef MEM_BOUNDS_CHECK_EN
                    if (MARin[31:ADDR_WIDTH] != '0) begin
                        state_nxt = BND_ERR;
                    end else begin
                        state_nxt = WriteReq ? WR_ISSUE : RD_ISSUE;
                    end
`else
                    state_nxt = WriteReq ? WR_ISSUE : RD_ISSUE;
`endif
                end
            end
            RD_ISSUE: begin
                state_nxt = RD_WAIT;
                cnt_nxt   = CW'(READ_WAIT - 1);
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = FINISH;
                    mdr_nxt   = Mdatain;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR_ISSUE: state_nxt = FINISH;
            // Rejected request: one strobe-free busy cycle so Done/Error land where a store's Done would.
            BND_ERR: begin
                state_nxt = FINISH;
                err_nxt   = 1'b1;
            end
            FINISH:   state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state      <= IDLE;
            cnt        <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Error      <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            MemAddress <= '0;
            MemDataOut <= '0;
            MDRdata    <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            Busy       <= (state_nxt != IDLE);
            Done       <= (state_nxt == FINISH);
            Error      <= err_nxt;
            MemRead    <= (state_nxt == RD_ISSUE) || (state_nxt == RD_WAIT);
            MemWrite   <= (state_nxt == WR_ISSUE);
            MemAddress <= addr_nxt;
            MemDataOut <= dout_nxt;
            MDRdata    <= mdr_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM, request-level reference model, directed and random requests.
module tb_mem_access_ctrl;
    localparam int RW = 1;

    logic        Clock = 1'b0;
    logic        Clear, Start, WriteReq;
    logic [31:0] MARin, MDRin;
    logic        Busy, Done, Error, MemRead, MemWrite;
    logic [31:0] MDRdata, MemDataOut, Mdatain;
    logic [8:0]  MemAddress;

    mem_access_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_WAIT(RW)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .WriteReq(WriteReq),
        .MARin(MARin), .MDRin(MDRin), .Busy(Busy), .Done(Done), .Error(Error),
        .MDRdata(MDRdata), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemAddress(MemAddress), .MemDataOut(MemDataOut), .Mdatain(Mdatain)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM seen by the DUT
    bit [31:0] ram [512];
    always @(posedge Clock) begin
        if (MemWrite) ram[MemAddress] <= MemDataOut;
        if (MemRead)  Mdatain <= ram[MemAddress];
    end

    // Reference: memory contents and expected holding register
    bit [31:0]   ref_mem [512];
    logic [31:0] exp_mdr = 32'h0;
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] mar, input logic [31:0] din,
                          input bit noise, input string tag);
        bit oob = 1'b0;
        int rd = 0, wcnt = 0, dn = 0, done_at = -1, err_at = -1, idle_at = -1;
        bit both = 1'b0, addr_bad = 1'b0, data_bad = 1'b0;
        int e_rd, e_wr, e_done, e_err, e_idle;
        logic [8:0] a;
        a = mar[8:0];
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (mar[31:9] != 23'd0);
`endif
        @(negedge Clock);
        Start = 1'b1; WriteReq = wr; MARin = mar; MDRin = din;
        @(posedge Clock);
        #1 Start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (MemRead) rd++;
            if (MemWrite) wcnt++;
            if (MemRead && MemWrite) both = 1'b1;
            if ((MemRead || MemWrite) && MemAddress !== a) addr_bad = 1'b1;
            if (MemWrite && MemDataOut !== din) data_bad = 1'b1;
            if (Done) begin dn++; if (done_at < 0) done_at = k; end
            if (Error && err_at < 0) err_at = k;
            if (!Busy) begin idle_at = k; break; end
            if (noise) begin
                Start = 1'($urandom_range(0, 1)); WriteReq = 1'($urandom_range(0, 1));
                MARin = $urandom; MDRin = $urandom;
            end
        end
        Start = 1'b0;
        if (oob) begin
            e_rd = 0; e_wr = 0; e_done = 1; e_err = 1; e_idle = 2;
        end else if (wr) begin
            e_rd = 0; e_wr = 1; e_done = 1; e_err = -1; e_idle = 2;
            ref_mem[a] = din;
        end else begin
            e_rd = 1 + RW; e_wr = 0; e_done = 1 + RW; e_err = -1; e_idle = 2 + RW;
            exp_mdr = ref_mem[a];
        end
        check({tag, " read_cycles"}, rd, e_rd);
        check({tag, " write_cycles"}, wcnt, e_wr);
        check({tag, " done_cycle"}, done_at, e_done);
        check({tag, " done_width"}, dn, 1);
        check({tag, " error_cycle"}, err_at, e_err);
        check({tag, " idle_cycle"}, idle_at, e_idle);
        check({tag, " both_strobes"}, both, 0);
        check({tag, " strobe_addr"}, addr_bad, 0);
        check({tag, " write_data"}, data_bad, 0);
        check({tag, " mdrdata"}, MDRdata, exp_mdr);
    endtask

    task automatic reset_checks();
        check("rst busy", Busy, 0);
        check("rst done", Done, 0);
        check("rst error", Error, 0);
        check("rst memread", MemRead, 0);
        check("rst memwrite", MemWrite, 0);
        check("rst memaddress", MemAddress, 0);
        check("rst memdataout", MemDataOut, 0);
        check("rst mdrdata", MDRdata, 0);
    endtask

    initial begin
        int q_done[$];
        int rd, per, waited;
        logic [31:0] mar;
        bit [8:0] pool [8] = '{9'd84, 9'd146, 9'd0, 9'd511, 9'd1, 9'd256, 9'd300, 9'd7};

        Clear = 1'b0; Start = 1'b0; WriteReq = 1'b0; MARin = '0; MDRin = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        reset_checks();
        Clear = 1'b1;

        // Store then load-back
        do_req(1'b1, 32'd84, 32'h0000_0097, 1'b0, "store84");
        do_req(1'b0, 32'd84, 32'h0, 1'b0, "load84");
        check("load84 value", MDRdata, 32'h0000_0097);

        // Back-to-back loads with Start held high
        do_req(1'b1, 32'd146, 32'h0000_0046, 1'b0, "store146");
        per = RW + 3;
        rd = 0;
        @(negedge Clock);
        Start = 1'b1; WriteReq = 1'b0; MARin = 32'd146;
        @(posedge Clock);
        for (int k = 0; k < 4 * per; k++) begin
            @(negedge Clock);
            if (Done) q_done.push_back(k);
            if (MemRead) rd++;
        end
        Start = 1'b0;
        check("b2b done_count", q_done.size(), 4);
        for (int n = 0; n < 4; n++)
            check("b2b done_pos", (n < q_done.size()) ? q_done[n] : -1, RW + 1 + n * per);
        check("b2b read_cycles", rd, 4 * (1 + RW));
        check("b2b mdrdata", MDRdata, 32'h0000_0046);
        waited = 0;
        while (Busy && waited < 20) begin @(negedge Clock); waited++; end
        check("b2b idle", Busy, 0);

        // Clear during RD_WAIT aborts the load
        @(negedge Clock);
        Start = 1'b1; WriteReq = 1'b0; MARin = 32'd84;
        @(posedge Clock);
        #1 Start = 1'b0;
        @(negedge Clock);
        check("abort memread_issue", MemRead, 1);
        @(negedge Clock);
        check("abort no_early_done", Done, 0);
        Clear = 1'b0;
        @(negedge Clock);
        check("abort memread", MemRead, 0);
        check("abort mdrdata", MDRdata, 0);
        check("abort done", Done, 0);
        check("abort busy", Busy, 0);
        Clear = 1'b1;
        exp_mdr = 32'h0;
        do_req(1'b0, 32'd84, 32'h0, 1'b0, "after_abort");

        // Upper address bits: wrap by default, rejected with the bounds check
        do_req(1'b0, 32'h0000_0254, 32'h0, 1'b0, "wrap254");
        check("wrap254 memaddress", MemAddress, 9'h054);

        // Random requests with noise on the inputs while busy
        for (int i = 0; i < 30; i++) begin
            mar = {($urandom_range(0, 3) == 0) ? 23'($urandom) : 23'd0, pool[$urandom_range(0, 7)]};
            do_req(1'($urandom_range(0, 1)), mar, $urandom, 1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the 512x32 synchronous RAM.
- Accepts one load/store request at a time from the control unit (MAR/MDR path) and drives the RAM's Read/Write/Address/data-in pins.
- Waits out the RAM read latency, captures Mdatain into a holding register and signals completion with a one-cycle Done pulse.
- Sits between the control unit/MDR and the RAM.

Parameters:
- ADDR_WIDTH, 9, RAM address width (512 words).
- DATA_WIDTH, 32, data word width.
- READ_WAIT, 1, cycles Read is held after the issue cycle before Mdatain is captured; must be >= 1.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Clear  in  1  reset, synchronous, active-low.
- Start  in  1  request strobe; sampled only when Busy=0.
- WriteReq  in  1  1=store, 0=load; sampled with Start.
- MARin  in  32  request word address.
- MDRin  in  DATA_WIDTH  store data; sampled with Start.
- Busy  out  1  request in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  out-of-range access pulse; valid only with MEM_BOUNDS_CHECK_EN.
- MDRdata  out  DATA_WIDTH  last captured load data.
- MemRead  out  1  to RAM Read.
- MemWrite  out  1  to RAM Write.
- MemAddress  out  ADDR_WIDTH  to RAM Address.
- MemDataOut  out  DATA_WIDTH  to RAM data-in (BusMuxOutC).
- Mdatain  in  DATA_WIDTH  from RAM data-out.

Behaviour:
- Registered outputs:
  - All outputs are registered.
  - Clear=0 at a rising edge: state IDLE; Busy, Done, Error, MemRead and MemWrite = 0; MemAddress, MemDataOut and MDRdata = 0.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, FINISH.
- IDLE:
  - Busy=0, no strobes.
  - Start=1 at edge E0: latch MARin[ADDR_WIDTH-1:0] into MemAddress, MDRin into MemDataOut, and WriteReq.
  - Go to RD_ISSUE or WR_ISSUE; Busy=1 from E0.
- Load path:
  - RD_ISSUE: MemRead=1 for one cycle, then RD_WAIT.
  - RD_WAIT: MemRead stays 1; a counter loads READ_WAIT-1 and decrements.
  - At the edge ending the last wait cycle: MDRdata <= Mdatain, MemRead=0, Done=1, state FINISH.
  - Load Done is visible after edge E0+1+READ_WAIT (E0+2 at default).
- Store path:
  - WR_ISSUE: MemWrite=1 with MemAddress and MemDataOut stable for one cycle.
  - Next edge: MemWrite=0, Done=1, state FINISH.
  - Store Done is visible after E0+1. MDRdata is unchanged by stores.
- FINISH:
  - Done=1 and Busy=1 for exactly one cycle; then IDLE with Done=0 and Busy=0.
  - Earliest next Start is sampled at the edge ending the first IDLE cycle.
- MemRead and MemWrite are never both 1.
- MemAddress and MemDataOut hold their values between requests.
- Start while Busy=1 is ignored entirely: no queuing, no error.
- Clear=0 mid-operation: abort at that edge, deassert strobes, no Done. A store in WR_ISSUE may or may not have completed in the RAM.
- Clear has priority over Start on the same edge.
- Address: MARin upper bits [31:ADDR_WIDTH] are dropped (wrap modulo 512) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - At Start, if MARin[31:ADDR_WIDTH] != 0, no RAM strobe is issued.
  - Go directly to FINISH: Done=1 and Error=1 together, visible after E0+1; MDRdata unchanged.
  - Error is 0 at all other times.
- Not defined: Error is tied 0 and addresses wrap as above.

Test Plan:
- Reset, then store: Clear=0 for 2 cycles -> all outputs 0. Start, WriteReq=1, MARin=84, MDRin=0x00000097 -> MemWrite=1 for exactly 1 cycle with MemAddress=84; Done after E0+1; Busy=0 after E0+2.
- Load-back: Start, WriteReq=0, MARin=84 -> MemRead high for 2 cycles; MDRdata=0x00000097 and Done=1 after E0+2; MemWrite stays 0.
- Back-to-back with ignored Start:
  - Hold Start=1 continuously with loads to 146 (preloaded 0x00000046).
  - Expect a new request every 4 cycles (READ_WAIT=1).
  - Start during Busy is not accepted; each Done is one cycle wide.
- Reset mid-load: Clear=0 during RD_WAIT -> MemRead=0 and MDRdata=0 next cycle; no Done; the following load completes normally.
- Address wrap and bounds:
  - MARin=0x00000254, load -> MemAddress=0x054, MDRdata=0x00000097.
  - With MEM_BOUNDS_CHECK_EN, same stimulus -> no MemRead; Done=1 and Error=1 after E0+1; MDRdata unchanged.
- READ_WAIT=3 build: load from 84 -> MemRead high 4 cycles; Done after E0+4.
